// File: rtl/interval_timer_if.sv
// interval_timer_if.sv - FSM-to-timer bundle: start/interval request, programming strobe, expired/1 Hz status
//
// Signals:
//   start_timer     1-cycle (re)start request
//   interval        duration select sampled with start_timer
//   Prog_Sync       program strobe, loads Time_Value into the register chosen by Time_Param_Sel
//   Time_Param_Sel  register to program: 00 base, 01 ext, 10 yel, 11 none
//   Time_Value      new duration, seconds
//   expired         1-cycle pulse when a countdown completes
//   one_hz_enable   1-cycle pulse per second
//   remaining       live countdown value (only with TIMER_REMAIN_EN)
// Modports: master = FSM / driver side, slave = timer side.
interface interval_timer_if;
    logic       start_timer;
    logic [1:0] interval;
    logic       Prog_Sync;
    logic [1:0] Time_Param_Sel;
    logic [3:0] Time_Value;
    logic       expired;
    logic       one_hz_enable;
`ifdef TIMER_REMAIN_EN
    logic [3:0] remaining;

    modport master (
        output start_timer, interval, Prog_Sync, Time_Param_Sel, Time_Value,
        input  expired, one_hz_enable, remaining
    );
    modport slave (
        input  start_timer, interval, Prog_Sync, Time_Param_Sel, Time_Value,
        output expired, one_hz_enable, remaining
    );
`else
    modport master (
        output start_timer, interval, Prog_Sync, Time_Param_Sel, Time_Value,
        input  expired, one_hz_enable
    );
    modport slave (
        input  start_timer, interval, Prog_Sync, Time_Param_Sel, Time_Value,
        output expired, one_hz_enable
    );
`endif
endinterface

// File: rtl/interval_timer.sv
// interval_timer.sv - programmable seconds countdown with 1 Hz enable for the traffic-light FSM
//
// Ports:
//   clk         system clock, rising edge
//   Reset_Sync  synchronous reset, active-low
//   bus         interval_timer_if.slave (start_timer, interval, Prog_Sync,
//               Time_Param_Sel, Time_Value in; expired, one_hz_enable out)
// Optional feature macro: TIMER_REMAIN_EN adds bus.remaining = live count.
module interval_timer #(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int T_BASE_DEF   = 6,
    parameter int T_EXT_DEF    = 3,
    parameter int T_YEL_DEF    = 2
) (
    input  logic             clk,
    input  logic             Reset_Sync,
    interval_timer_if.slave  bus
);
    localparam int                DIV_W    = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKS_PER_SEC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             expired_q, expired_d;
    logic [DIV_W-1:0] div_q;
    logic             one_hz_q;
    logic [3:0]       t_base_q, t_ext_q, t_yel_q;
    logic [3:0]       sel_dur;
    logic [3:0]       prog_val;
    logic             tick;
    logic             start;
    logic             prog;

    assign start = bus.start_timer;
    assign prog  = bus.Prog_Sync;

    // The countdown uses the divider terminal count directly so that the
    // decrement lands on the same edge that raises one_hz_enable; this makes
    // expiry land exactly N*CLKS_PER_SEC edges after the start edge.
    assign tick = (div_q == DIV_LAST);

    // A zero duration would never expire, so it is stored as one second.
    assign prog_val = (bus.Time_Value == 4'd0) ? 4'd1 : bus.Time_Value;

    always_comb begin
        sel_dur = t_base_q;
        case (bus.interval)
            2'b01:   sel_dur = t_ext_q;
            2'b10:   sel_dur = t_yel_q;
            default: sel_dur = t_base_q;
        endcase
    end

    // Divider: restarting or programming realigns the second boundary.
    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            div_q    <= '0;
            one_hz_q <= 1'b0;
        end else begin
            one_hz_q <= tick;
            if (start || prog || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            t_base_q <= 4'(T_BASE_DEF);
            t_ext_q  <= 4'(T_EXT_DEF);
            t_yel_q  <= 4'(T_YEL_DEF);
        end else if (prog) begin
            case (bus.Time_Param_Sel)
                2'b00:   t_base_q <= prog_val;
                2'b01:   t_ext_q  <= prog_val;
                2'b10:   t_yel_q  <= prog_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    // Priority: programming, then (re)start, then countdown. A restart on the
    // final tick therefore reloads instead of expiring.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (prog) begin
            state_d = IDLE;
            count_d = 4'd0;
        end else if (start) begin
            state_d = RUN;
            count_d = sel_dur;
        end else if (state_q == RUN && tick && count_q != 4'd0) begin
            if (count_q == 4'd1) begin
                state_d   = IDLE;
                count_d   = 4'd0;
                expired_d = 1'b1;
            end else begin
                count_d = count_q - 4'd1;
            end
        end
    end

    assign bus.expired       = expired_q;
    assign bus.one_hz_enable = one_hz_q;
`ifdef TIMER_REMAIN_EN
    assign bus.remaining     = count_q;
`endif
endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer against a deadline-based reference model
module tb_interval_timer;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: absolute edge numbers, not counters.
    int   edge_no    = 0;
    int   last_clear = 0;
    int   deadline   = 0;
    bit   active     = 1'b0;
    int   dur [3];

    interval_timer_if bus ();

    interval_timer #(
        .CLKS_PER_SEC(C),
        .T_BASE_DEF  (6),
        .T_EXT_DEF   (3),
        .T_YEL_DEF   (2)
    ) dut (
        .clk       (clk),
        .Reset_Sync(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit st, input logic [1:0] iv,
                        input bit pg, input logic [1:0] sel, input logic [3:0] val);
        bit exp_expired;
        bit exp_one_hz;
        int idx;
        rst_n              = ~r;
        bus.start_timer    = st;
        bus.interval       = iv;
        bus.Prog_Sync      = pg;
        bus.Time_Param_Sel = sel;
        bus.Time_Value     = val;
        @(posedge clk);
        edge_no++;
        // A second boundary falls every C edges after the latest realignment.
        exp_one_hz  = !r && (((edge_no - last_clear) % C) == 0);
        exp_expired = 1'b0;
        if (r) begin
            active = 1'b0;
            dur[0] = 6; dur[1] = 3; dur[2] = 2;
        end else if (pg) begin
            active = 1'b0;
            if (sel != 2'b11) dur[sel] = (val == 0) ? 1 : int'(val);
        end else if (st) begin
            idx      = (iv == 2'b11) ? 0 : int'(iv);
            active   = 1'b1;
            deadline = edge_no + dur[idx] * C;
        end else if (active && edge_no == deadline) begin
            exp_expired = 1'b1;
            active      = 1'b0;
        end
        if (r || pg || st) last_clear = edge_no;
        #1;
        n_vec++;
        assert (bus.expired === exp_expired)
        else begin
            n_err++;
            $error("FAIL expired edge=%0d observed=%b expected=%b", edge_no, bus.expired, exp_expired);
        end
        n_vec++;
        assert (bus.one_hz_enable === exp_one_hz)
        else begin
            n_err++;
            $error("FAIL one_hz_enable edge=%0d observed=%b expected=%b", edge_no, bus.one_hz_enable, exp_one_hz);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0, 2'b00, 4'd0);
    endtask

    task automatic start(input logic [1:0] iv);
        step(1'b0, 1'b1, iv, 1'b0, 2'b00, 4'd0);
    endtask

    task automatic program_reg(input logic [1:0] sel, input logic [3:0] val);
        step(1'b0, 1'b0, 2'b00, 1'b1, sel, val);
    endtask

    initial begin
        dur[0] = 6; dur[1] = 3; dur[2] = 2;
        rst_n = 1'b0;
        bus.start_timer = 1'b0; bus.interval = 2'b00; bus.Prog_Sync = 1'b0;
        bus.Time_Param_Sel = 2'b00; bus.Time_Value = 4'd0;

        // Reset state
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
        step(1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 4'd9);
        idle(1);

        // Base duration: 24 cycles
        start(2'b00);
        idle(30);

        // Yellow programmed to 5 s
        program_reg(2'b10, 4'd5);
        start(2'b10);
        idle(25);

        // Extended programmed to 0 -> 1 s
        program_reg(2'b01, 4'd0);
        start(2'b01);
        idle(8);

        // Retrigger at cycle 10 with interval 01
        program_reg(2'b01, 4'd3);
        start(2'b00);
        idle(9);
        start(2'b01);
        idle(16);

        // Restart coincident with the final tick
        start(2'b01);
        idle(11);
        start(2'b10);
        idle(12);

        // Reset at cycle 8 of a run, then defaults 6/3/2
        program_reg(2'b00, 4'd9);
        start(2'b00);
        idle(7);
        step(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 4'd0);
        idle(30);
        start(2'b00); idle(26);
        start(2'b01); idle(14);
        start(2'b10); idle(10);
        start(2'b11); idle(26);

        // Prog_Sync mid-run, select none, then Prog_Sync with start
        start(2'b00);
        idle(5);
        program_reg(2'b11, 4'd9);
        idle(30);
        step(1'b0, 1'b1, 2'b00, 1'b1, 2'b10, 4'd4);
        idle(12);
        for (int i = 0; i < 6; i++) program_reg(2'b00, 4'd1);
        idle(10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 24) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 79) == 0,
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
